// File: rtl/fetch_unit.sv
// Decoupled instruction fetch front end: credit-limited in-order read requests,
// a DEPTH-entry prefetch FIFO of {pc, instr}, and flush-on-redirect with stale-response drop.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic                   mem_rd_req_valid_o,
  input  logic                   mem_rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr_o,
  input  logic                   mem_rd_resp_valid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rd_data_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(INSTR_WIDTH / 8);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  pc_mem [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic          accept, resp, push, pop;
  logic [CW:0]   used;

  // One extra bit so the credit sum cannot wrap.
  assign used               = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign mem_rd_req_valid_o = used < (CW+1)'(DEPTH);
  assign mem_rd_addr_o      = fetch_pc_q;
  assign instr_valid_o      = count_q != '0;
  assign instr_o            = instr_mem[rd_ptr_q];
  assign instr_pc_o         = pc_mem[rd_ptr_q];

  assign accept = mem_rd_req_valid_o && mem_rd_req_ready_i;
  assign resp   = mem_rd_resp_valid_i && (inflight_q != '0);
  assign push   = resp && (drop_q == '0) && !redirect_i;
  assign pop    = instr_valid_o && instr_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(resp);
    drop_d     = drop_q - CW'(resp && (drop_q != '0));
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
    if (push)   resp_pc_d  = resp_pc_q + PC_INC;
    // Everything still outstanding after this cycle's updates is stale.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      drop_d     = inflight_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= mem_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_rd_resp_valid_i && inflight_q == '0))
        else $error("fetch_unit: read response with no request in flight");
      assert (!(push && count_q == CW'(DEPTH) && !pop))
        else $error("fetch_unit: prefetch FIFO overflow");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency and a
// stream-level reference (after reset/redirect to P, requests and deliveries run P, P+4, ...).
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        mem_rd_req_valid_o;
  logic        mem_rd_req_ready_i;
  logic [15:0] mem_rd_addr_o;
  logic        mem_rd_resp_valid_i;
  logic [31:0] mem_rd_data_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [15:0] instr_pc_o;

  fetch_unit #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(32),
    .DEPTH      (4),
    .RESET_PC   (16'hFFF8)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .mem_rd_req_valid_o (mem_rd_req_valid_o),
    .mem_rd_req_ready_i (mem_rd_req_ready_i),
    .mem_rd_addr_o      (mem_rd_addr_o),
    .mem_rd_resp_valid_i(mem_rd_resp_valid_i),
    .mem_rd_data_i      (mem_rd_data_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_pop = 0;
  logic [15:0] exp_req, exp_del;
  bit          last_acc, last_pop;

  function automatic logic [31:0] memdata(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge: drive this cycle's inputs, model the cycle, advance.
  task automatic step(input bit mrdy, input bit drdy, input bit redir,
                      input logic [15:0] rpc, input int lat);
    bit acc, pp;
    acc = mem_rd_req_valid_o && mrdy;
    pp  = instr_valid_o && drdy;
    mem_rd_req_ready_i = mrdy;
    instr_ready_i      = drdy;
    redirect_i         = redir;
    redirect_pc_i      = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rd_resp_valid_i = 1'b1;
      mem_rd_data_i       = memdata(memq[0].addr);
      memq.delete(0);
    end else begin
      mem_rd_resp_valid_i = 1'b0;
      mem_rd_data_i       = $urandom;
    end
    if (acc) begin
      check("req_addr", mem_rd_addr_o, exp_req);
      memq.push_back('{addr: mem_rd_addr_o, due: cyc + lat});
      exp_req = exp_req + 16'd4;
    end
    if (pp) begin
      check("pop_pc", instr_pc_o, exp_del);
      check("pop_data", instr_o, memdata(exp_del));
      exp_del = exp_del + 16'd4;
      n_pop++;
    end
    if (redir) begin
      exp_req = rpc;
      exp_del = rpc;
    end
    last_acc = acc;
    last_pop = pp;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_i             = 1'b1;
    mem_rd_req_ready_i  = 1'b0;
    mem_rd_resp_valid_i = 1'b0;
    mem_rd_data_i       = '0;
    redirect_i          = 1'b0;
    redirect_pc_i       = '0;
    instr_ready_i       = 1'b0;
    memq.delete();
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    exp_req = 16'hFFF8;
    exp_del = 16'hFFF8;
    check("rst_req_valid", mem_rd_req_valid_o, 1);
    check("rst_req_addr", mem_rd_addr_o, 16'hFFF8);
    check("rst_instr_valid", instr_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wrap_addrs [4];
    int          n, gaps, pops0;
    bit          found;
    logic [15:0] first_pc;
    logic [31:0] first_data;
    wrap_addrs = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};

    do_reset();

    // Streaming with single-cycle memory across the address wrap.
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) check("wrap_addr", mem_rd_addr_o, wrap_addrs[i]);
      if (i >= 2 && !instr_valid_o) gaps++;
      step(1, 1, 0, '0, 1);
    end
    check("stream_gaps", gaps, 0);

    // Redirect in a cycle that also carries an accept and a response.
    check("pre_redir_busy", {mem_rd_req_valid_o, mem_rd_resp_valid_i}, 2'b11);
    step(1, 1, 1, 16'h0000, 1);
    check("redir_req_valid", mem_rd_req_valid_o, 1);
    check("redir_req_addr", mem_rd_addr_o, 16'h0000);
    check("redir_instr_valid", instr_valid_o, 0);
    repeat (10) step(1, 1, 0, '0, 1);

    // Decode stalled: credit limits to DEPTH outstanding, one pop frees one.
    step(1, 0, 1, 16'h0200, 1);
    n = 0;
    repeat (12) begin
      step(1, 0, 0, '0, 1);
      n += int'(last_acc);
    end
    check("stall_accepts", n, 4);
    check("stall_req_valid", mem_rd_req_valid_o, 0);
    check("stall_head_pc", instr_pc_o, 16'h0200);
    step(1, 1, 0, '0, 1);
    check("stall_pop", last_pop, 1);
    n = 0;
    repeat (6) begin
      step(1, 0, 0, '0, 1);
      n += int'(last_acc);
    end
    check("stall_reissue", n, 1);

    // Three requests in flight at latency 3, then redirect to 0x100.
    step(1, 1, 1, 16'h0040, 3);
    n = 0;
    repeat (3) begin
      step(1, 1, 0, '0, 3);
      n += int'(last_acc);
    end
    check("lat3_accepts", n, 3);
    step(0, 1, 1, 16'h0100, 3);
    check("lat3_instr_valid", instr_valid_o, 0);
    check("lat3_req_addr", mem_rd_addr_o, 16'h0100);
    found = 0;
    first_pc = '0;
    first_data = '0;
    for (int i = 0; i < 20; i++) begin
      if (!found && instr_valid_o) begin
        found = 1;
        first_pc = instr_pc_o;
        first_data = instr_o;
      end
      step(1, 1, 0, '0, 3);
    end
    check("lat3_found", found, 1);
    check("lat3_first_pc", first_pc, 16'h0100);
    check("lat3_first_data", first_data, memdata(16'h0100));

    // Random ready/latency with periodic redirects.
    pops0 = n_pop;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] rpc;
      rpc = 16'($urandom) & 16'hFFFC;
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6,
           $urandom_range(31, 0) == 0, rpc, int'($urandom_range(3, 1)));
    end
    repeat (20) step(1, 1, 0, '0, 1);
    check("random_progress", (n_pop - pops0) > 300, 1);

    // Reset mid-stream returns to the reset state.
    repeat (3) step(1, 1, 0, '0, 1);
    do_reset();
    repeat (6) step(1, 1, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
